// File: rtl/irq_controller_if.sv
// Bundles the request/mask/enable and trap-handshake signals between the
// peripherals/core side (master) and the interrupt controller (slave).
interface irq_controller_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      int_req;
  logic [31:0]      int_mask;
  logic             mie_global;
  logic             irq_ack;
  logic             mret;
  logic             irq;
  logic [31:0]      irq_cause;
  logic [31:0]      int_fin;
  logic [CNT_W-1:0] irq_count;

  modport master (
    output int_req, int_mask, mie_global, irq_ack, mret,
    input  irq, irq_cause, int_fin, irq_count
  );

  modport slave (
    input  int_req, int_mask, mie_global, irq_ack, mret,
    output irq, irq_cause, int_fin, irq_count
  );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority interrupt arbiter: selects the lowest pending source, raises irq
// with its mcause, waits for ack and mret, then pulses a one-hot completion.
module irq_controller #(
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010,
  parameter int          CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVICE, FINISH} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      sel_reg, sel_next;
  logic [31:0]      cause_reg, cause_next;
  logic [31:0]      fin_reg, fin_next;
  logic             irq_reg, irq_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [31:0] pending;
  logic [31:0] win_onehot;
  logic [4:0]  win_idx;

  assign pending    = bus.int_req & bus.int_mask;
  // Two's-complement trick isolates the lowest set bit, i.e. the winner.
  assign win_onehot = pending & (~pending + 32'd1);

  genvar gi, gk;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_idx
      logic [31:0] col;
      for (gk = 0; gk < 32; gk++) begin : g_bit
        if (((gk >> gi) & 1) != 0) begin : g_on
          assign col[gk] = win_onehot[gk];
        end else begin : g_off
          assign col[gk] = 1'b0;
        end
      end
      assign win_idx[gi] = |col;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cause_next = cause_reg;
    fin_next   = '0;
    irq_next   = 1'b0;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (bus.mie_global && (pending != 32'd0)) begin
          state_next = PENDING;
          sel_next   = win_onehot;
          cause_next = CAUSE_BASE + {27'd0, win_idx};
          irq_next   = 1'b1;
        end
      end
      PENDING: begin
        // Ack wins over a simultaneous withdrawal; mask changes never cancel.
        if (bus.irq_ack) begin
          state_next = SERVICE;
        end else if ((bus.int_req & sel_reg) == 32'd0) begin
          state_next = IDLE;
          sel_next   = '0;
          cause_next = '0;
        end else begin
          irq_next = bus.mie_global;
        end
      end
      SERVICE: begin
        if (bus.mret) begin
          state_next = FINISH;
          fin_next   = sel_reg;
          count_next = (&count_reg) ? count_reg : count_reg + 1'b1;
        end
      end
      FINISH: begin
        state_next = IDLE;
        sel_next   = '0;
        cause_next = '0;
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
        cause_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      cause_reg <= '0;
      fin_reg   <= '0;
      irq_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cause_reg <= cause_next;
      fin_reg   <= fin_next;
      irq_reg   <= irq_next;
      count_reg <= count_next;
    end
  end

  assign bus.irq       = irq_reg;
  assign bus.irq_cause = cause_reg;
  assign bus.int_fin   = fin_reg;
  assign bus.irq_count = count_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: stimulus queues expected irq/fin events,
// a monitor pops and compares them whenever the DUT raises irq or pulses int_fin.
module tb_irq_controller;

  logic clk;
  logic rst;
  logic done;
  int   checks;
  int   failures;

  typedef struct {
    bit          is_fin;
    logic [31:0] val;
  } ev_t;
  ev_t exp_q[$];

  irq_controller_if #(.CNT_W(4)) bus ();

  irq_controller #(.CAUSE_BASE(32'h8000_0010), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_fin, input logic [31:0] val);
    ev_t e;
    e.is_fin = is_fin;
    e.val    = val;
    exp_q.push_back(e);
  endtask

  task automatic pop(input bit is_fin, input logic [31:0] act, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected event actual=%h required=none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e.is_fin != is_fin || act !== e.val) begin
        failures++;
        $display("FAIL %s actual=%h(fin=%0d) required=%h(fin=%0d)", name, act, is_fin, e.val, e.is_fin);
      end else begin
        $display("%t %s %h", $time, is_fin ? "int_fin" : "irq cause", act);
      end
    end
  endtask

  task automatic wait_irq(input string name);
    for (int i = 0; i < 8; i++) begin
      if (bus.irq) break;
      tick();
    end
    check(name, {31'd0, bus.irq}, 32'd1);
  endtask

  // Drives ack then mret from PENDING and checks the completion afterwards.
  task automatic complete(input logic [31:0] cause, input logic [31:0] fin, input int cnt);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check("irq_low_in_service", {31'd0, bus.irq}, 32'd0);
    check("cause_held_service", bus.irq_cause, cause);
    push(1'b1, fin);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    bus.int_req = bus.int_req & ~fin;
    tick();
    check("fin_one_cycle", bus.int_fin, 32'd0);
    check("count", {28'd0, bus.irq_count}, cnt);
  endtask

  task automatic serve(input logic [31:0] cause, input logic [31:0] fin, input int cnt);
    push(1'b0, cause);
    wait_irq("irq_raise");
    complete(cause, fin, cnt);
  endtask

  task automatic stimulus();
    // Reset state
    #2;
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_cause", bus.irq_cause, 32'd0);
    check("rst_fin", bus.int_fin, 32'd0);
    check("rst_count", {28'd0, bus.irq_count}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: single source, one-edge latency
    bus.int_mask   = 32'hFFFF_FFFF;
    bus.mie_global = 1'b1;
    bus.int_req    = 32'h20;
    push(1'b0, 32'h8000_0015);
    tick();
    check("t1_latency", {31'd0, bus.irq}, 32'd1);
    complete(32'h8000_0015, 32'h20, 1);

    // T2: lowest index wins, remaining request served next
    bus.int_req = 32'h24;
    serve(32'h8000_0012, 32'h04, 2);
    serve(32'h8000_0015, 32'h20, 3);

    // T3: masking / global enable
    bus.int_mask = 32'h0;
    bus.int_req  = 32'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_masked", {31'd0, bus.irq}, 32'd0);
    end
    bus.int_mask   = 32'hFFFF_FFFF;
    bus.mie_global = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_mie_off_idle", {31'd0, bus.irq}, 32'd0);
    end
    bus.mie_global = 1'b1;
    push(1'b0, 32'h8000_0015);
    tick();
    check("t3_pending", {31'd0, bus.irq}, 32'd1);
    bus.mie_global = 1'b0;
    tick();
    check("t3_mie_off_pending", {31'd0, bus.irq}, 32'd0);
    bus.int_mask = 32'h0;
    bus.int_req  = 32'h21;
    tick();
    check("t3_no_cancel", {31'd0, bus.irq}, 32'd0);
    check("t3_no_preempt", bus.irq_cause, 32'h8000_0015);
    bus.mie_global = 1'b1;
    push(1'b0, 32'h8000_0015);
    tick();
    check("t3_mie_on", {31'd0, bus.irq}, 32'd1);
    complete(32'h8000_0015, 32'h20, 4);
    tick();
    tick();
    check("t3_bit0_masked", {31'd0, bus.irq}, 32'd0);
    bus.int_mask = 32'hFFFF_FFFF;
    serve(32'h8000_0010, 32'h01, 5);

    // T4: withdrawal in PENDING
    bus.int_req = 32'h20;
    push(1'b0, 32'h8000_0015);
    tick();
    check("t4_irq", {31'd0, bus.irq}, 32'd1);
    bus.int_req = 32'h0;
    tick();
    check("t4_withdraw_irq", {31'd0, bus.irq}, 32'd0);
    check("t4_withdraw_cause", bus.irq_cause, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t4_count", {28'd0, bus.irq_count}, 32'd5);

    // T5: async reset mid-SERVICE
    bus.int_req = 32'h20;
    push(1'b0, 32'h8000_0015);
    wait_irq("t5_irq");
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_irq", {31'd0, bus.irq}, 32'd0);
    check("t5_cause", bus.irq_cause, 32'd0);
    check("t5_fin", bus.int_fin, 32'd0);
    check("t5_count", {28'd0, bus.irq_count}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.int_req = 32'h0;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick();
    tick();
    check("t5_no_fin", bus.int_fin, 32'd0);
    check("t5_idle", {31'd0, bus.irq}, 32'd0);

    // T6: saturation and simultaneous ack+mret
    for (int k = 1; k <= 15; k++) begin
      bus.int_req = 32'h20;
      serve(32'h8000_0015, 32'h20, k);
    end
    bus.int_req = 32'h20;
    push(1'b0, 32'h8000_0015);
    wait_irq("t6_irq");
    bus.irq_ack = 1'b1;
    bus.mret    = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.mret    = 1'b0;
    check("t6_ack_taken", {31'd0, bus.irq}, 32'd0);
    tick();
    tick();
    check("t6_mret_dropped", bus.int_fin, 32'd0);
    push(1'b1, 32'h20);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    bus.int_req = 32'h0;
    tick();
    check("t6_saturate", {28'd0, bus.irq_count}, 32'hF);
    tick();
    done = 1'b1;
  endtask

  task automatic monitor();
    logic irq_prev;
    irq_prev = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        irq_prev = 1'b0;
      end else begin
        if (bus.irq && !irq_prev) pop(1'b0, bus.irq_cause, "irq_cause");
        if (bus.int_fin != 32'd0) pop(1'b1, bus.int_fin, "int_fin");
        check("fin_onehot0", {31'd0, $onehot0(bus.int_fin)}, 32'd1);
        check("irq_fin_exclusive", {31'd0, bus.irq && (bus.int_fin != 32'd0)}, 32'd0);
        irq_prev = bus.irq;
      end
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    done           = 1'b0;
    rst            = 1'b1;
    bus.int_req    = 32'h0;
    bus.int_mask   = 32'h0;
    bus.mie_global = 1'b0;
    bus.irq_ack    = 1'b0;
    bus.mret       = 1'b0;
    fork
      stimulus();
      monitor();
    join
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
